fetch_ctrl: RTL and testbench

//  Sequences the IF stage against a variable-latency instruction memory (req/ack).

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the IF stage against a variable-latency req/ack
// instruction memory. Inserts bubbles while memory is busy, parks a fetched
// word while the hazard unit stalls ID, and throws away a fetch that was
// already in flight when EX redirects the PC.
//
// Handshake: im_req is raised for exactly one outstanding request and is held,
// with im_addr stable, until the cycle in which im_ack=1. That cycle completes
// the transfer and im_rdata is valid only then. An abandoned (stale) request
// is still held to completion and its data is ignored.
module fetch_ctrl #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_out,
  input  logic [1:0]      BranchCtrl,
  input  logic            hazard_stall,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_ack,
  input  logic [XLEN-1:0] im_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic            PC_write,
  output logic            IFID_RegWrite,
  output logic            InstrFlush
);

  // ISSUE latches the fetch address, REQ waits on memory, HOLD keeps a word
  // during a hazard stall, DROP waits out a request made stale by a redirect.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            redir;
  logic [XLEN-1:0] pc_next;

  assign redir   = (BranchCtrl != 2'b00);
  assign pc_next = pc_out + XLEN'(PC_STEP);

  // Next-state and IF-stage control; everything is forced low while in reset.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    buf_d         = buf_q;
    im_req        = 1'b0;
    im_addr       = addr_q;
    instr_out     = '0;
    PC_write      = 1'b0;
    IFID_RegWrite = 1'b0;
    InstrFlush    = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        addr_d        = pc_out;
        IFID_RegWrite = !hazard_stall;
        InstrFlush    = 1'b1;
        if (redir) begin
          // Redirect target is not in the PC yet; relatch it next cycle.
          PC_write      = 1'b1;
          IFID_RegWrite = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        im_req = 1'b1;
        if (redir) begin
          PC_write      = 1'b1;
          IFID_RegWrite = 1'b1;
          InstrFlush    = 1'b1;
          state_d       = im_ack ? S_ISSUE : S_DROP;
        end else if (im_ack && !hazard_stall) begin
          instr_out     = im_rdata;
          PC_write      = 1'b1;
          IFID_RegWrite = 1'b1;
          addr_d        = pc_next;
        end else if (im_ack) begin
          buf_d   = im_rdata;
          state_d = S_HOLD;
        end else begin
          IFID_RegWrite = !hazard_stall;
          InstrFlush    = 1'b1;
        end
      end
      S_HOLD: begin
        instr_out = buf_q;
        if (redir) begin
          PC_write      = 1'b1;
          IFID_RegWrite = 1'b1;
          InstrFlush    = 1'b1;
          state_d       = S_ISSUE;
        end else if (!hazard_stall) begin
          PC_write      = 1'b1;
          IFID_RegWrite = 1'b1;
          addr_d        = pc_next;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        im_req        = 1'b1;
        IFID_RegWrite = !hazard_stall;
        InstrFlush    = 1'b1;
        PC_write      = redir;
        if (im_ack) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase
    if (!rst) begin
      im_req        = 1'b0;
      im_addr       = '0;
      instr_out     = '0;
      PC_write      = 1'b0;
      IFID_RegWrite = 1'b0;
      InstrFlush    = 1'b0;
    end
  end

  // State, fetch address and parked word; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_ISSUE;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch sequencer, an IF PC register model
// and a random-latency memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [1:0]  BranchCtrl;
  logic        hazard_stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] instr_out;
  logic        PC_write;
  logic        IFID_RegWrite;
  logic        InstrFlush;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // clock
  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .BranchCtrl(BranchCtrl),
    .hazard_stall(hazard_stall), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .instr_out(instr_out),
    .PC_write(PC_write), .IFID_RegWrite(IFID_RegWrite), .InstrFlush(InstrFlush)
  );

  // Model: one pending request (fresh or stale) or one parked word, plus the
  // last latched fetch address. Neither pending nor parked means "about to issue".
  logic        m_req = 1'b0, m_stale = 1'b0, m_buf = 1'b0;
  logic [31:0] m_addr = '0, m_bufd = '0;
  logic [31:0] pc_reg = '0;
  logic [31:0] tgt = '0;

  logic        e_req, e_pcw, e_ifid, e_flush;
  logic [31:0] e_addr, e_instr;
  logic        redir;

  assign redir = (BranchCtrl != 2'b00);

  // expected outputs for the current cycle
  always_comb begin
    e_req = 1'b0; e_addr = m_addr; e_instr = '0;
    e_pcw = 1'b0; e_ifid = 1'b0; e_flush = 1'b0;
    if (!rst) begin
      e_addr = '0;
    end else if (m_buf) begin
      e_instr = m_bufd;
      if (redir) begin e_pcw = 1; e_ifid = 1; e_flush = 1; end
      else if (!hazard_stall) begin e_pcw = 1; e_ifid = 1; end
    end else if (!m_req) begin
      e_flush = 1; e_ifid = !hazard_stall | redir; e_pcw = redir;
    end else if (m_stale) begin
      e_req = 1; e_flush = 1; e_ifid = !hazard_stall; e_pcw = redir;
    end else begin
      e_req = 1;
      if (redir) begin e_pcw = 1; e_ifid = 1; e_flush = 1; end
      else if (im_ack && !hazard_stall) begin
        e_instr = im_rdata; e_pcw = 1; e_ifid = 1;
      end else if (!im_ack) begin
        e_ifid = !hazard_stall; e_flush = 1;
      end
    end
  end

  // model and IF PC register advance
  always @(posedge clk) begin
    if (!rst) begin
      m_req <= 0; m_stale <= 0; m_buf <= 0; m_addr <= '0; m_bufd <= '0;
      pc_reg <= '0;
    end else begin
      if (e_pcw) pc_reg <= redir ? tgt : pc_reg + 32'd4;
      if (m_buf) begin
        if (redir) m_buf <= 0;
        else if (!hazard_stall) begin
          m_buf <= 0; m_req <= 1; m_stale <= 0; m_addr <= pc_out + 32'd4;
        end
      end else if (!m_req) begin
        m_addr <= pc_out;
        if (!redir) begin m_req <= 1; m_stale <= 0; end
      end else if (m_stale) begin
        if (im_ack) m_req <= 0;
      end else if (redir) begin
        if (im_ack) m_req <= 0; else m_stale <= 1;
      end else if (im_ack) begin
        if (!hazard_stall) m_addr <= pc_out + 32'd4;
        else begin m_buf <= 1; m_bufd <= im_rdata; m_req <= 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("im_req", 32'(im_req), 32'(e_req));
      chk("im_addr", im_addr, e_addr);
      chk("instr_out", instr_out, e_instr);
      chk("PC_write", 32'(PC_write), 32'(e_pcw));
      chk("IFID_RegWrite", 32'(IFID_RegWrite), 32'(e_ifid));
      chk("InstrFlush", 32'(InstrFlush), 32'(e_flush));
    end
  end

  // driver: apply one cycle of inputs just after the edge, return at negedge
  task automatic step(input logic r, input logic [1:0] bc, input logic hs,
                      input logic ack, input logic [31:0] rd, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = r; BranchCtrl = bc; hazard_stall = hs; im_ack = ack; im_rdata = rd;
    tgt = t; pc_out = pc_reg;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  int lat;

  initial begin
    rst = 0; BranchCtrl = 0; hazard_stall = 0; im_ack = 0; im_rdata = 0; pc_out = 0;

    // reset: two cycles, everything low
    step(0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("rst_req", 32'(im_req), 0);
    chk("rst_addr", im_addr, 0);
    // release: issue cycle then request at 0
    step(1, 0, 0, 0, 32'h0, 0);
    chk("rel_issue_req", 32'(im_req), 0);
    chk("rel_issue_flush", 32'(InstrFlush), 1);

    // zero-wait memory streams 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 32'h13 + 32'(i), 0);
      chk("stream_req", 32'(im_req), 1);
      chk("stream_addr", im_addr, 32'(i * 4));
      chk("stream_instr", instr_out, 32'h13 + 32'(i));
      chk("stream_pcw", 32'(PC_write), 1);
      chk("stream_flush", 32'(InstrFlush), 0);
    end

    // two wait states, ack on the third request cycle at 0xC
    step(1, 0, 0, 0, 32'h0, 0);
    chk("wait_ifid", 32'(IFID_RegWrite), 1);
    chk("wait_pcw", 32'(PC_write), 0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("wait_flush", 32'(InstrFlush), 1);
    step(1, 0, 0, 1, 32'hCAFE0001, 0);
    chk("wait_ack_instr", instr_out, 32'hCAFE0001);
    chk("wait_ack_pcw", 32'(PC_write), 1);

    // stalled ack parks 0xDEADBEEF for three cycles
    step(1, 0, 1, 1, 32'hDEADBEEF, 0);
    chk("stall_ack_pcw", 32'(PC_write), 0);
    chk("stall_ack_ifid", 32'(IFID_RegWrite), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 32'h0, 0);
      chk("hold_req", 32'(im_req), 0);
      chk("hold_pcw", 32'(PC_write), 0);
    end
    step(1, 0, 0, 0, 32'h0, 0);
    chk("hold_release_instr", instr_out, 32'hDEADBEEF);
    chk("hold_release_pcw", 32'(PC_write), 1);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("after_hold_addr", im_addr, 32'h14);

    // redirect to 0x100 while waiting at 0x14; stale fetch completes, is dropped
    step(1, 2'b01, 0, 0, 32'h0, 32'h100);
    chk("redir_pcw", 32'(PC_write), 1);
    chk("redir_flush", 32'(InstrFlush), 1);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("drop_addr", im_addr, 32'h14);
    step(1, 0, 0, 1, 32'h55555555, 0);
    chk("drop_ack_addr", im_addr, 32'h14);
    chk("drop_ack_instr", instr_out, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("drop_issue_req", 32'(im_req), 0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("redir_target_addr", im_addr, 32'h100);

    // reset mid-request, then redirect coincident with ack
    step(0, 0, 0, 0, 32'h0, 0);
    chk("midrst_req", 32'(im_req), 0);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("midrst_issue_req", 32'(im_req), 0);
    step(1, 2'b10, 0, 1, 32'h77777777, 32'hFFFFFFFC);
    chk("ackredir_flush", 32'(InstrFlush), 1);
    chk("ackredir_pcw", 32'(PC_write), 1);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("ackredir_issue_req", 32'(im_req), 0);
    // PC wraps from 0xFFFFFFFC to 0x0
    step(1, 0, 0, 1, 32'h1, 0);
    chk("wrap_top_addr", im_addr, 32'hFFFFFFFC);
    step(1, 0, 0, 0, 32'h0, 0);
    chk("wrap_zero_addr", im_addr, 32'h0);

    // randomized traffic with random memory latency
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      logic       r, hs, ack;
      logic [1:0] bc;
      r   = ($urandom_range(0, 199) != 0);
      bc  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hs  = ($urandom_range(0, 3) == 0);
      ack = r && m_req && (lat == 0);
      step(r, bc, hs, ack, $urandom, $urandom & 32'hFFFFFFFC);
      if (ack || !r) lat = $urandom_range(0, 3);
      else if (lat > 0) lat--;
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
